pdh_dac_axis_tx: RTL

//  Transmit side of the 32-bit packed two-channel AXI-Stream data path.
//  The ADC path receives ch1 in tdata[15:0] and ch2 in tdata[31:16]; this block drives DAC samples out in the same packing.
//  It accepts signed 16-bit per-channel results from the PDH core and saturates them to 14-bit two's complement.

---
 rtl/pdh_pkg.sv | 37 +++
 rtl/pdh_sync_fifo.sv | 65 ++++++
 rtl/pdh_dac_axis_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pdh_pkg.sv
// Shared types, limits and the DAC saturation helper for the
// PDH DAC transmit path.
package pdh_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    PARK   = 2'd3
  } dac_tx_state_t;

  localparam logic signed [15:0] DAC_MAX = 16'sd8191;
  localparam logic signed [15:0] DAC_MIN = -16'sd8192;

  // Returns {clip, sample[13:0]}; clip is set when the input
  // was outside the 14-bit two's complement range.
  function automatic logic [14:0] sat_dac(
    input logic signed [15:0] x
  );
    logic [14:0] r;
    if (x > DAC_MAX)
      r = {1'b1, DAC_MAX[13:0]};
    else if (x < DAC_MIN)
      r = {1'b1, DAC_MIN[13:0]};
    else
      r = {1'b0, x[13:0]};
    return r;
  endfunction

  // Sign-extend a 14-bit DAC sample to a 16-bit lane.
  function automatic logic [15:0] sext14(
    input logic [13:0] s
  );
    return {{2{s[13]}}, s};
  endfunction

endpackage

// File: rtl/pdh_sync_fifo.sv
// Synchronous show-ahead FIFO with a level counter and flush.
// Ports: clk, rst_i (async high), flush_i, push_i/din_i,
//   pop_i/dout_o, full_o, empty_o, level_o (0..DEPTH).
module pdh_sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level == LW'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;
  assign dout_o  = mem[rd_ptr];

  // A full FIFO never takes a push, even with a same-cycle pop.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push && !flush_i)
      mem[wr_ptr] <= din_i;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pdh_dac_axis_tx.sv
// PDH DAC transmit: saturates ch1/ch2 to 14 bits, buffers pairs
// and streams {ch2,ch1} as an AXIS master; parks at 0 when off.
// Ports: clk, rst_i, en_i, ch1/ch2_data_i, data_valid_i,
//   data_ready_o, M_AXIS_*, underrun_cnt_o, sat_cnt_o, status_o.
module pdh_dac_axis_tx
  import pdh_pkg::*;
#(
  parameter int IN_WIDTH         = 16,
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [IN_WIDTH-1:0]         ch1_data_i,
  input  logic [IN_WIDTH-1:0]         ch2_data_i,
  input  logic                        data_valid_i,
  output logic                        data_ready_o,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata_o,
  output logic                        M_AXIS_tvalid_o,
  input  logic                        M_AXIS_tready_i,
  output logic [15:0]                 underrun_cnt_o,
  output logic [15:0]                 sat_cnt_o,
  output logic [7:0]                  status_o
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);

  dac_tx_state_t               state;
  logic [14:0]                 s1;
  logic [14:0]                 s2;
  logic                        clip;
  logic [AXIS_TDATA_WIDTH-1:0] word;
  logic                        push;
  logic                        hs;
  logic                        fifo_pop;
  logic                        fifo_flush;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [LW-1:0]               fifo_level;
  logic [LW-1:0]               lvl_nxt;
  logic [AXIS_TDATA_WIDTH-1:0] fifo_dout;

  assign s1   = sat_dac(ch1_data_i);
  assign s2   = sat_dac(ch2_data_i);
  assign clip = s1[14] || s2[14];
  assign word = {sext14(s2[13:0]), sext14(s1[13:0])};

  // A pair offered in the cycle en_i falls is dropped even
  // though the registered ready is still high.
  assign push = data_valid_i && data_ready_o && en_i;
  assign hs   = M_AXIS_tvalid_o && M_AXIS_tready_i;

  always_comb begin
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state)
      PRIME: begin
        if (!en_i)
          fifo_flush = 1'b1;
        else if (!fifo_empty)
          fifo_pop = 1'b1;
      end
      STREAM: begin
        if (hs && !en_i)
          fifo_flush = 1'b1;
        else if (hs && !fifo_empty)
          fifo_pop = 1'b1;
      end
      default: ;
    endcase
  end

  // Ready is registered from the level the FIFO will hold after
  // this edge, so it never admits a push into a full FIFO.
  always_comb begin
    if (fifo_flush)
      lvl_nxt = '0;
    else
      lvl_nxt = fifo_level + LW'(push) - LW'(fifo_pop);
  end

  pdh_sync_fifo #(
    .WIDTH (AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (push),
    .din_i   (word),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      data_ready_o    <= 1'b0;
      M_AXIS_tdata_o  <= '0;
      M_AXIS_tvalid_o <= 1'b0;
      underrun_cnt_o  <= '0;
      sat_cnt_o       <= '0;
    end else begin
      data_ready_o <= en_i && (lvl_nxt != LW'(FIFO_DEPTH));
      if (push && clip && (sat_cnt_o != 16'hFFFF))
        sat_cnt_o <= sat_cnt_o + 1'b1;
      unique case (state)
        IDLE: begin
          if (en_i)
            state <= PRIME;
        end
        PRIME: begin
          if (!en_i) begin
            state <= IDLE;
          end else if (!fifo_empty) begin
            M_AXIS_tdata_o  <= fifo_dout;
            M_AXIS_tvalid_o <= 1'b1;
            state           <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            if (!en_i) begin
              M_AXIS_tdata_o <= '0;
              state          <= PARK;
            end else if (!fifo_empty) begin
              M_AXIS_tdata_o <= fifo_dout;
            end else if (underrun_cnt_o != 16'hFFFF) begin
              underrun_cnt_o <= underrun_cnt_o + 1'b1;
            end
          end
        end
        PARK: begin
          if (hs) begin
            M_AXIS_tvalid_o <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign status_o = {3'b000, 3'(fifo_level), state};

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule
